// File: rtl/hjb_quote_requester.sv
// hjb_quote_requester: drives the HJB calculator from market ticks and
// returns bid/ask quotes over valid/ready, coalescing ticks while busy.
// Ports: clk/rst; tick_* in (valid/ready); calc_* operands, enable and
// results; quote_* out (valid/ready); busy plus two saturating counters.
module hjb_quote_requester #(
   parameter int TIMEOUT_CYCLES = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_valid,
   output logic        tick_ready,
   input  logic [63:0] tick_mid_price,
   input  logic [31:0] tick_inventory,
   input  logic [63:0] tick_volatility,
   output logic [63:0] calc_mid_price,
   output logic [63:0] calc_volatility,
   output logic [31:0] calc_inventory,
   output logic        calc_en,
   input  logic        calc_done,
   input  logic [63:0] calc_bid,
   input  logic [63:0] calc_ask,
   output logic        quote_valid,
   input  logic        quote_ready,
   output logic [63:0] quote_bid,
   output logic [63:0] quote_ask,
   output logic [31:0] quote_latency,
   output logic        quote_timeout,
   output logic        busy,
   output logic [15:0] timeout_count,
   output logic [15:0] coalesce_count
);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [63:0] op_mid_q, op_mid_d, op_vol_q, op_vol_d;
   logic [31:0] op_inv_q, op_inv_d;
   logic        en_q, en_d;
   logic [31:0] cnt_q, cnt_d;
   logic        pend_vld_q, pend_vld_d;
   logic [63:0] pend_mid_q, pend_mid_d, pend_vol_q, pend_vol_d;
   logic [31:0] pend_inv_q, pend_inv_d;
   logic        qv_q, qv_d;
   logic [63:0] bid_q, bid_d, ask_q, ask_d;
   logic [31:0] lat_q, lat_d;
   logic        to_q, to_d;
   logic [15:0] to_cnt_q, to_cnt_d, co_cnt_q, co_cnt_d;
   logic        dnlow_q, dnlow_d;

   logic tick_acc, launch, stash, hs_ok, dn_ok;

   assign tick_ready = ~rst;
   assign tick_acc   = tick_valid & tick_ready;
   // Handshake either already happened or happens this cycle.
   assign hs_ok      = ~qv_q | quote_ready;
   // calc_done low seen earlier in DRAIN or right now.
   assign dn_ok      = dnlow_q | ~calc_done;

   always_comb begin
      state_d    = state_q;
      op_mid_d   = op_mid_q;
      op_vol_d   = op_vol_q;
      op_inv_d   = op_inv_q;
      en_d       = en_q;
      cnt_d      = cnt_q;
      pend_vld_d = pend_vld_q;
      pend_mid_d = pend_mid_q;
      pend_vol_d = pend_vol_q;
      pend_inv_d = pend_inv_q;
      qv_d       = qv_q;
      bid_d      = bid_q;
      ask_d      = ask_q;
      lat_d      = lat_q;
      to_d       = to_q;
      to_cnt_d   = to_cnt_q;
      co_cnt_d   = co_cnt_q;
      dnlow_d    = dnlow_q;
      launch     = 1'b0;
      stash      = 1'b0;

      case (state_q)
         IDLE: begin
            launch = tick_acc | pend_vld_q;
         end
         WAIT: begin
            cnt_d = cnt_q + 32'd1;
            stash = tick_acc;
            if (calc_done) begin
               bid_d   = calc_bid;
               ask_d   = calc_ask;
               lat_d   = cnt_q + 32'd1;
               to_d    = 1'b0;
               qv_d    = 1'b1;
               en_d    = 1'b0;
               dnlow_d = 1'b0;
               state_d = DRAIN;
            end else if (cnt_q + 32'd1 == TMO) begin
               bid_d   = 64'd0;
               ask_d   = 64'd0;
               lat_d   = TMO;
               to_d    = 1'b1;
               qv_d    = 1'b1;
               en_d    = 1'b0;
               dnlow_d = 1'b0;
               if (to_cnt_q != 16'hFFFF)
                  to_cnt_d = to_cnt_q + 16'd1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!calc_done)
               dnlow_d = 1'b1;
            if (hs_ok && dn_ok) begin
               qv_d = 1'b0;
               if (tick_acc || pend_vld_q)
                  launch = 1'b1;
               else
                  state_d = IDLE;
            end else begin
               if (qv_q && quote_ready)
                  qv_d = 1'b0;
               stash = tick_acc;
            end
         end
         default: state_d = IDLE;
      endcase

      // A live tick beats the pending slot; the slot is dropped either way.
      if (launch) begin
         if (tick_acc) begin
            op_mid_d = tick_mid_price;
            op_inv_d = tick_inventory;
            op_vol_d = tick_volatility;
         end else begin
            op_mid_d = pend_mid_q;
            op_inv_d = pend_inv_q;
            op_vol_d = pend_vol_q;
         end
         pend_vld_d = 1'b0;
         en_d       = 1'b1;
         cnt_d      = 32'd0;
         dnlow_d    = 1'b0;
         state_d    = WAIT;
      end

      if (stash) begin
         pend_mid_d = tick_mid_price;
         pend_inv_d = tick_inventory;
         pend_vol_d = tick_volatility;
         pend_vld_d = 1'b1;
         if (pend_vld_q && co_cnt_q != 16'hFFFF)
            co_cnt_d = co_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_mid_q   <= '0;
         op_vol_q   <= '0;
         op_inv_q   <= '0;
         en_q       <= 1'b0;
         cnt_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_mid_q <= '0;
         pend_vol_q <= '0;
         pend_inv_q <= '0;
         qv_q       <= 1'b0;
         bid_q      <= '0;
         ask_q      <= '0;
         lat_q      <= '0;
         to_q       <= 1'b0;
         to_cnt_q   <= '0;
         co_cnt_q   <= '0;
         dnlow_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_mid_q   <= op_mid_d;
         op_vol_q   <= op_vol_d;
         op_inv_q   <= op_inv_d;
         en_q       <= en_d;
         cnt_q      <= cnt_d;
         pend_vld_q <= pend_vld_d;
         pend_mid_q <= pend_mid_d;
         pend_vol_q <= pend_vol_d;
         pend_inv_q <= pend_inv_d;
         qv_q       <= qv_d;
         bid_q      <= bid_d;
         ask_q      <= ask_d;
         lat_q      <= lat_d;
         to_q       <= to_d;
         to_cnt_q   <= to_cnt_d;
         co_cnt_q   <= co_cnt_d;
         dnlow_q    <= dnlow_d;
      end
   end

   assign calc_mid_price  = op_mid_q;
   assign calc_volatility = op_vol_q;
   assign calc_inventory  = op_inv_q;
   assign calc_en         = en_q;
   assign quote_valid     = qv_q;
   assign quote_bid       = bid_q;
   assign quote_ask       = ask_q;
   assign quote_latency   = lat_q;
   assign quote_timeout   = to_q;
   assign busy            = (state_q != IDLE);
   assign timeout_count   = to_cnt_q;
   assign coalesce_count  = co_cnt_q;

endmodule
